// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types: datapath width, fetch FSM states and the
// {pc, instr} record carried from fetch to decode.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_KILL
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of everything the fetch stage exchanges with program_counter,
// instruction memory, execute (redirects) and decode.
interface instr_fetch_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc;
    logic            pc_enable;
    logic            pc_load;
    logic [XLEN-1:0] pc_addr;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_addr;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;

    // master = the fetch stage, slave = its surroundings
    modport master (
        input  pc, redirect_valid, redirect_addr, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, if_ready,
        output pc_enable, pc_load, pc_addr, imem_req_valid, imem_req_addr,
               if_valid, if_pc, if_instr
    );

    modport slave (
        output pc, redirect_valid, redirect_addr, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, if_ready,
        input  pc_enable, pc_load, pc_addr, imem_req_valid, imem_req_addr,
               if_valid, if_pc, if_instr
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} entries; flush empties it
// and takes priority over a push or pop in the same cycle.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type ENTRY_T = fetch_entry_t,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  ENTRY_T        push_data,
    output logic [CW-1:0] count,
    output ENTRY_T        head
);

    ENTRY_T        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage is cleared on reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues one outstanding word read per PC, buffers responses for
// decode, and steps or reloads program_counter.
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter int XLEN  = rv32i_pkg::XLEN,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    fetch_state_t    state;
    logic [XLEN-1:0] req_pc;
    logic [CW-1:0]   count;
    logic [CW:0]     occupied;
    logic            space;
    logic            req_valid;
    logic            accept;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // A pending response already owns a FIFO slot, so it counts against space.
    assign occupied  = {1'b0, count} + {{CW{1'b0}}, (state != S_REQ)};
    assign space     = occupied < (CW + 1)'(DEPTH);
    assign req_valid = ~rst & (state == S_REQ) & space & ~bus.redirect_valid;
    assign accept    = req_valid & bus.imem_req_ready;

    assign push = (state == S_WAIT) & bus.imem_rsp_valid & ~bus.redirect_valid;
    assign pop  = (count != '0) & bus.if_ready & ~bus.redirect_valid;

    assign push_entry.pc    = req_pc;
    assign push_entry.instr = bus.imem_rsp_data;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = rst ? '0 : {bus.pc[XLEN-1:2], 2'b00};
    assign bus.pc_enable      = ~rst & (bus.redirect_valid | accept);
    assign bus.pc_load        = ~rst & bus.redirect_valid;
    assign bus.pc_addr        = (~rst & bus.redirect_valid) ? bus.redirect_addr : '0;

    assign bus.if_valid = (count != '0);
    assign bus.if_pc    = head.pc;
    assign bus.if_instr = head.instr;

    // A response arriving in a redirect cycle retires the read (and is dropped),
    // so the FSM never waits for a second response that will not come.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_REQ;
            req_pc <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (accept) begin
                        req_pc <= bus.pc;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        state <= S_REQ;
                    end else if (bus.redirect_valid) begin
                        state <= S_KILL;
                    end
                end
                S_KILL: begin
                    if (bus.imem_rsp_valid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .push_data (push_entry),
        .count     (count),
        .head      (head)
    );

    // Memory must never answer while no read is pending.
    assert property (@(posedge clk) disable iff (rst)
        !((state == S_REQ) && bus.imem_rsp_valid));

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a transaction-level model of the
// instruction stream, with models of program_counter and instruction memory.
module tb_instr_fetch;
    import rv32i_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    instr_fetch_if #(.XLEN(XLEN)) bus ();

    instr_fetch #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one read in flight (possibly killed), FIFO occupancy,
    // and the PC the next delivered instruction must carry.
    bit          outstanding;
    bit          killed;
    int          occ;
    logic [31:0] expPc;
    logic [31:0] pcReg;
    bit          memBusy;
    int          memDelay;
    logic [31:0] memAddr;
    bit          rspNow;
    bit          redir;
    logic [31:0] redirAddr;
    bit          prevStall;
    logic [31:0] prevAddr;
    int          readyPct;
    int          ifReadyPct;
    int          redirPct;
    int          maxLat;
    int          stallCycles;
    bit          redirOnWait;
    bit          redirOnRsp;
    logic [31:0] forcedTarget;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus();
        rspNow = memBusy && (memDelay == 0);
        bus.pc             = pcReg;
        bus.imem_rsp_valid = rspNow;
        bus.imem_rsp_data  = rspNow ? instrOf(memAddr) : $urandom;
        if (stallCycles > 0) begin
            bus.imem_req_ready = 1'b0;
            stallCycles--;
        end else begin
            bus.imem_req_ready = ($urandom_range(99) < readyPct);
        end
        bus.if_ready = ($urandom_range(99) < ifReadyPct);
        redir     = ($urandom_range(99) < redirPct);
        redirAddr = $urandom & 32'h0000_fffc;
        if (redirOnWait && outstanding && !killed && !rspNow) begin
            redir       = 1'b1;
            redirAddr   = forcedTarget;
            redirOnWait = 1'b0;
        end
        if (redirOnRsp && outstanding && !killed && rspNow) begin
            redir        = 1'b1;
            redirAddr    = forcedTarget;
            bus.if_ready = 1'b1;
            redirOnRsp   = 1'b0;
        end
        bus.redirect_valid = redir;
        bus.redirect_addr  = redirAddr;
    endtask

    task automatic evalCycle();
        bit expReq;
        bit acc;
        bit popNow;
        expReq = !outstanding && (occ < DEPTH) && !redir;
        acc    = expReq && bus.imem_req_ready;
        popNow = (occ != 0) && bus.if_ready && !redir;

        checkOutput("req_valid", bus.imem_req_valid, expReq);
        if (expReq) checkOutput("req_addr", bus.imem_req_addr, {pcReg[31:2], 2'b00});
        if (prevStall && expReq) checkOutput("req_addr_stable", bus.imem_req_addr, prevAddr);
        checkOutput("pc_enable", bus.pc_enable, redir | acc);
        checkOutput("pc_load", bus.pc_load, redir);
        if (redir) checkOutput("pc_addr", bus.pc_addr, redirAddr);
        checkOutput("if_valid", bus.if_valid, occ != 0);
        if (popNow) begin
            checkOutput("if_pc", bus.if_pc, expPc);
            checkOutput("if_instr", bus.if_instr, instrOf(expPc));
        end
        prevStall = expReq && !bus.imem_req_ready;
        prevAddr  = bus.imem_req_addr;

        if (redir) begin
            occ   = 0;
            expPc = redirAddr;
            if (outstanding && rspNow) begin
                outstanding = 1'b0;
                killed      = 1'b0;
            end else if (outstanding) begin
                killed = 1'b1;
            end
        end else begin
            if (popNow) begin
                occ--;
                expPc += 32'd4;
            end
            if (outstanding && rspNow) begin
                if (!killed) occ++;
                outstanding = 1'b0;
                killed      = 1'b0;
            end
            if (acc) outstanding = 1'b1;
        end

        if (redir) pcReg = redirAddr;
        else if (acc) pcReg = pcReg + 32'd4;

        if (rspNow) memBusy = 1'b0;
        else if (memBusy) memDelay--;
        if (acc) begin
            memBusy  = 1'b1;
            memAddr  = {bus.imem_req_addr[31:2], 2'b00};
            memDelay = $urandom_range(maxLat - 1, 0);
        end
    endtask

    task automatic oneCycle();
        @(negedge clk);
        applyStimulus();
        #1;
        evalCycle();
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) oneCycle();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        bus.pc = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.if_ready       = 1'b0;
        #1;
        checkOutput("rst_if_valid", bus.if_valid, 0);
        checkOutput("rst_req_valid", bus.imem_req_valid, 0);
        checkOutput("rst_pc_enable", bus.pc_enable, 0);
        checkOutput("rst_pc_load", bus.pc_load, 0);
        checkOutput("rst_if_pc", bus.if_pc, 0);
        checkOutput("rst_if_instr", bus.if_instr, 0);
        outstanding = 1'b0;
        killed      = 1'b0;
        occ         = 0;
        expPc       = '0;
        pcReg       = '0;
        memBusy     = 1'b0;
        memDelay    = 0;
        prevStall   = 1'b0;
        stallCycles = 0;
        redirOnWait = 1'b0;
        redirOnRsp  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit found;
        readyPct = 100; ifReadyPct = 100; redirPct = 0; maxLat = 1;
        forcedTarget = '0;
        doReset();

        // sequential fetch at zero-wait memory
        runCycles(40);

        // decode stalls: buffer fills, then drains without gaps
        ifReadyPct = 0;
        runCycles(12);
        ifReadyPct = 100;
        runCycles(20);

        // redirect while a response is pending
        maxLat = 3; forcedTarget = 32'h0000_0100; redirOnWait = 1'b1;
        runCycles(25);

        // redirect coincident with response and decode pop
        maxLat = 1; forcedTarget = 32'h0000_0200; redirOnRsp = 1'b1;
        runCycles(25);

        // memory not ready for three cycles
        runCycles(3);
        stallCycles = 3;
        runCycles(12);

        // reset while a read is pending with one entry buffered
        ifReadyPct = 0; maxLat = 3;
        for (int i = 0; i < 60 && !(outstanding && occ == 1); i++) oneCycle();
        found = outstanding && (occ == 1);
        checkOutput("rst_mid_setup", found, 1);
        doReset();
        ifReadyPct = 100; maxLat = 1;
        runCycles(20);

        // random traffic
        readyPct = 70; ifReadyPct = 60; redirPct = 5; maxLat = 4;
        runCycles(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
